step_sequencer: RTL and testbench

//  Initiator side of the delay-counter handshake: accepts move commands (step count, direction, delay).

---
 rtl/step_sequencer.sv | 151 +++++++++++++++
 tb/tb_step_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Stepper-motor step sequencer: steps the 4-coil phase table and handshakes with an external delay counter.
// Defining HALF_STEP_EN selects the 8-entry half-step table instead of the 4-entry full-step table.
module step_sequencer #(
  parameter int         STEP_W    = 16,
  parameter int         DELAY_W   = 8,
  parameter logic [3:0] PHASE_RST = 4'b1100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [STEP_W-1:0]  cmd_steps,
  input  logic               cmd_dir,
  input  logic [DELAY_W-1:0] cmd_delay,
  input  logic               abort,
  input  logic               run_en,
  output logic               dly_start,
  output logic               dly_enable,
  output logic [DELAY_W-1:0] dly_value,
  input  logic               dly_done,
  output logic [3:0]         phase,
  output logic               busy,
  output logic               cmd_done,
  output logic [STEP_W-1:0]  steps_left
);

`ifdef HALF_STEP_EN
  localparam int TBL_N = 8;
  localparam int IDX_W = 3;

  function automatic logic [3:0] tbl(input logic [IDX_W-1:0] i);
    case (i)
      3'd0:    tbl = 4'b1000;
      3'd1:    tbl = 4'b1100;
      3'd2:    tbl = 4'b0100;
      3'd3:    tbl = 4'b0110;
      3'd4:    tbl = 4'b0010;
      3'd5:    tbl = 4'b0011;
      3'd6:    tbl = 4'b0001;
      default: tbl = 4'b1001;
    endcase
  endfunction
`else
  localparam int TBL_N = 4;
  localparam int IDX_W = 2;

  function automatic logic [3:0] tbl(input logic [IDX_W-1:0] i);
    case (i)
      2'd0:    tbl = 4'b1100;
      2'd1:    tbl = 4'b0110;
      2'd2:    tbl = 4'b0011;
      default: tbl = 4'b1001;
    endcase
  endfunction
`endif

  // Table position is recovered from the registered phase, so the reset value only has to be a table entry.
  function automatic logic [IDX_W-1:0] idx_of(input logic [3:0] p);
    idx_of = '0;
    for (int i = 0; i < TBL_N; i++) begin
      if (tbl(IDX_W'(i)) == p) idx_of = IDX_W'(i);
    end
  endfunction

  typedef enum logic [1:0] {IDLE, STEP, ARM, WAIT} state_t;

  state_t           state;
  state_t           state_next;
  logic             dir;
  logic             load_cmd;
  logic             advance;
  logic             dec_steps;
  logic             done_set;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] next_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_cmd   = 1'b0;
    advance    = 1'b0;
    dec_steps  = 1'b0;
    done_set   = 1'b0;
    cmd_ready  = (state == IDLE) && !abort;
    busy       = (state != IDLE);
    dly_start  = (state == STEP);
    dly_enable = (state == WAIT) && run_en;

    if (abort) begin
      state_next = IDLE;
      done_set   = (state != IDLE);
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            load_cmd = 1'b1;
            if (cmd_steps != '0) state_next = STEP;
            else                 done_set   = 1'b1;
          end
        end
        STEP: begin
          advance    = 1'b1;
          state_next = ARM;
        end
        // A done left over from the previous delay is still visible here, so it is deliberately ignored.
        ARM: state_next = WAIT;
        WAIT: begin
          if (dly_done) begin
            dec_steps = (steps_left != '0);
            if (steps_left <= STEP_W'(1)) begin
              state_next = IDLE;
              done_set   = 1'b1;
            end else begin
              state_next = STEP;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    cur_idx  = idx_of(phase);
    next_idx = dir ? cur_idx + IDX_W'(1) : cur_idx - IDX_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= PHASE_RST;
      steps_left <= '0;
      dly_value  <= '0;
      dir        <= 1'b0;
      cmd_done   <= 1'b0;
    end else begin
      cmd_done <= done_set;
      if (load_cmd) begin
        steps_left <= cmd_steps;
        dly_value  <= cmd_delay;
        dir        <= cmd_dir;
      end
      if (advance)   phase      <= tbl(next_idx);
      if (dec_steps) steps_left <= steps_left - STEP_W'(1);
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer with a behavioural delay counter.
// Build with HALF_STEP_EN defined to also exercise the half-step table.
module tb_step_sequencer;
  localparam int STEP_W  = 16;
  localparam int DELAY_W = 8;
  localparam int LIMIT   = 300;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [STEP_W-1:0]  cmd_steps = '0;
  logic               cmd_dir = 1'b0;
  logic [DELAY_W-1:0] cmd_delay = '0;
  logic               abort = 1'b0;
  logic               run_en = 1'b1;
  logic               dly_start;
  logic               dly_enable;
  logic [DELAY_W-1:0] dly_value;
  logic               dly_done;
  logic [3:0]         phase;
  logic               busy;
  logic               cmd_done;
  logic [STEP_W-1:0]  steps_left;

  logic               model_done;
  logic               model_armed;
  logic [DELAY_W-1:0] model_cnt;
  logic               force_done = 1'b0;

  typedef struct packed {
    logic [15:0] steps;
    logic [7:0]  delay;
    logic [3:0]  phase;
  } exp_t;

  exp_t       exp_start[$];
  exp_t       exp_done[$];
  logic [3:0] exp_phase[$];

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  logic [3:0] last_phase = 4'b0000;

`ifdef HALF_STEP_EN
  localparam int TBL_N = 8;
  localparam int RST_IDX = 1;
  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
  localparam int TBL_N = 4;
  localparam int RST_IDX = 0;
  logic [3:0] tbl [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
`endif
  int model_idx = RST_IDX;

  step_sequencer #(.STEP_W(STEP_W), .DELAY_W(DELAY_W), .PHASE_RST(4'b1100)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_delay(cmd_delay), .abort(abort),
    .run_en(run_en), .dly_start(dly_start), .dly_enable(dly_enable), .dly_value(dly_value),
    .dly_done(dly_done), .phase(phase), .busy(busy), .cmd_done(cmd_done), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  // Delay counter: done clears on the start edge and rises after dly_value enabled edges.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_done  <= 1'b0;
      model_armed <= 1'b0;
      model_cnt   <= '0;
    end else if (dly_start) begin
      model_done  <= 1'b0;
      model_armed <= 1'b1;
      model_cnt   <= dly_value;
    end else if (dly_enable && model_armed) begin
      if (model_cnt <= 1) begin
        model_done  <= 1'b1;
        model_armed <= 1'b0;
      end else begin
        model_cnt <= model_cnt - 1'b1;
      end
    end
  end

  assign dly_done = model_done | force_done;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic report_fail(input string name, input logic [31:0] actual);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=%0h expected=none", name, actual);
  endtask

  // Monitor: every phase change, arm pulse and completion pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] p;
    if (reset) begin
      last_phase = phase;
    end else begin
      if (phase !== last_phase) begin
        if (exp_phase.size() == 0) report_fail("unexpected_phase", {28'd0, phase});
        else begin
          p = exp_phase.pop_front();
          check_output("phase_seq", {28'd0, phase}, {28'd0, p});
        end
        last_phase = phase;
      end
      if (dly_start === 1'b1) begin
        start_cnt++;
        if (exp_start.size() == 0) report_fail("unexpected_start", {16'd0, steps_left});
        else begin
          e = exp_start.pop_front();
          check_output("start_steps_left", {16'd0, steps_left}, {16'd0, e.steps});
          check_output("start_dly_value", {24'd0, dly_value}, {24'd0, e.delay});
        end
      end
      if (cmd_done === 1'b1) begin
        if (exp_done.size() == 0) report_fail("unexpected_cmd_done", {16'd0, steps_left});
        else begin
          e = exp_done.pop_front();
          check_output("done_steps_left", {16'd0, steps_left}, {16'd0, e.steps});
          check_output("done_phase", {28'd0, phase}, {28'd0, e.phase});
        end
      end
    end
  end

  // Queue n_adv arm pulses and phase advances; done_steps < 0 means no completion is expected.
  task automatic expect_move(input int steps, input bit dir, input int delay, input int n_adv, input int done_steps);
    exp_t e;
    for (int i = 0; i < n_adv; i++) begin
      e.steps = 16'(steps - i);
      e.delay = 8'(delay);
      e.phase = 4'b0;
      exp_start.push_back(e);
      model_idx = dir ? (model_idx + 1) % TBL_N : (model_idx + TBL_N - 1) % TBL_N;
      exp_phase.push_back(tbl[model_idx]);
    end
    if (done_steps >= 0) begin
      e.steps = 16'(done_steps);
      e.delay = 8'd0;
      e.phase = tbl[model_idx];
      exp_done.push_back(e);
    end
  endtask

  // Called at a negedge; leaves cmd_valid low shortly after the accepting edge.
  task automatic apply_stimulus(input int steps, input bit dir, input int delay);
    cmd_valid = 1'b1;
    cmd_steps = STEP_W'(steps);
    cmd_dir   = dir;
    cmd_delay = DELAY_W'(delay);
    #1;
    check_output("accept_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output int busy_low);
    int n;
    n = 0;
    busy_low = 0;
    do begin
      @(negedge clk);
      n++;
      if (cmd_done !== 1'b1 && busy !== 1'b1) busy_low++;
    end while (cmd_done !== 1'b1 && n < LIMIT);
    if (cmd_done !== 1'b1) report_fail({name, "_timeout"}, 32'(n));
  endtask

  task automatic wait_wait_state(input string name, input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dly_enable === 1'b1 && steps_left == STEP_W'(target)) && n < LIMIT);
    if (!(dly_enable === 1'b1 && steps_left == STEP_W'(target))) report_fail({name, "_timeout"}, 32'(n));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_low;
    int s0;
    int bad;

    repeat (2) @(negedge clk);
    check_output("rst_phase", {28'd0, phase}, 32'hC);
    check_output("rst_steps_left", {16'd0, steps_left}, 32'd0);
    check_output("rst_dly_value", {24'd0, dly_value}, 32'd0);
    check_output("rst_ctrl", {27'd0, cmd_ready, busy, dly_start, dly_enable, cmd_done}, 32'b10000);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: forward 3 steps");
    s0 = start_cnt;
    expect_move(3, 1'b1, 5, 3, 0);
    apply_stimulus(3, 1'b1, 5);
    wait_done("t1", busy_low);
    check_output("t1_start_count", 32'(start_cnt - s0), 32'd3);

    $display("[TB] test 2: reverse 5 steps with wrap");
    expect_move(1, 1'b1, 2, 1, 0);
    apply_stimulus(1, 1'b1, 2);
    wait_done("t2_prep", busy_low);
    expect_move(5, 1'b0, 3, 5, 0);
    apply_stimulus(5, 1'b0, 3);
    wait_done("t2", busy_low);
    check_output("t2_busy_gaps", 32'(busy_low), 32'd0);

    $display("[TB] test 3: zero-step command");
    s0 = start_cnt;
    expect_move(0, 1'b1, 5, 0, 0);
    apply_stimulus(0, 1'b1, 5);
    @(negedge clk);
    check_output("t3_cmd_done", {31'd0, cmd_done}, 32'd1);
    check_output("t3_ready_busy", {30'd0, cmd_ready, busy}, 32'b10);
    check_output("t3_no_start", 32'(start_cnt - s0), 32'd0);

    $display("[TB] test 4: stale done held high");
    force_done = 1'b1;
    expect_move(4, 1'b1, 7, 4, 0);
    apply_stimulus(4, 1'b1, 7);
    wait_done("t4", busy_low);
    force_done = 1'b0;

    $display("[TB] test 5: abort in WAIT");
    expect_move(10, 1'b1, 3, 4, 7);
    apply_stimulus(10, 1'b1, 3);
    wait_wait_state("t5_wait", 7);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check_output("t5_idle_after_abort", {30'd0, cmd_ready, busy}, 32'b10);
    expect_move(2, 1'b1, 2, 2, 0);
    apply_stimulus(2, 1'b1, 2);
    wait_done("t5_next", busy_low);

    $display("[TB] test 6: pause with run_en low");
    expect_move(3, 1'b1, 4, 3, 0);
    apply_stimulus(3, 1'b1, 4);
    wait_wait_state("t6_wait", 3);
    run_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dly_enable !== 1'b0 || steps_left !== STEP_W'(3) || busy !== 1'b1) bad++;
    end
    check_output("t6_frozen", 32'(bad), 32'd0);
    run_en = 1'b1;
    wait_done("t6", busy_low);

    $display("[TB] test 7: async reset mid-move");
    expect_move(5, 1'b1, 6, 2, -1);
    apply_stimulus(5, 1'b1, 6);
    wait_wait_state("t7_wait", 4);
    #2 reset = 1'b1;
    #1;
    check_output("t7_rst_phase", {28'd0, phase}, 32'hC);
    check_output("t7_rst_steps_left", {16'd0, steps_left}, 32'd0);
    check_output("t7_rst_ctrl", {27'd0, cmd_ready, busy, dly_start, dly_enable, cmd_done}, 32'b10000);
    model_idx = RST_IDX;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] test 8: abort with command offered in IDLE");
    s0 = start_cnt;
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_steps = STEP_W'(3);
    cmd_dir   = 1'b1;
    #1;
    check_output("t8_ready_blocked", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1 abort = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_output("t8_still_idle", {29'd0, busy, cmd_done, cmd_ready}, 32'b001);
    repeat (3) @(negedge clk);
    check_output("t8_no_start", 32'(start_cnt - s0), 32'd0);

`ifdef HALF_STEP_EN
    $display("[TB] test 9: half-step full revolution");
    expect_move(8, 1'b1, 2, 8, 0);
    apply_stimulus(8, 1'b1, 2);
    wait_done("t9", busy_low);
    check_output("t9_end_phase", {28'd0, phase}, 32'hC);
`endif

    repeat (3) @(negedge clk);
    check_output("left_phase_exp", 32'(exp_phase.size()), 32'd0);
    check_output("left_start_exp", 32'(exp_start.size()), 32'd0);
    check_output("left_done_exp", 32'(exp_done.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
